simple_merger: RTL and testbench

- Inverse of the 4-way simple router: merges four independent input streams onto one output stream.
- Round-robin arbitration over inputs 0-3; tags each output word with its source index so a downstream router can steer replies back.
- Registered output stage with valid/ready handshake on every port; sits between the router's four leaf consumers and a shared single-lane sink.

---
 rtl/simple_merger.sv | 154 +++++++++++++++
 tb/tb_simple_merger.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_merger.sv
// -----------------------------------------------------------------------------
// simple_merger
//
// Merges four independent valid/ready input streams onto one registered output
// stream. Inputs are arbitrated round-robin: the scan starts at the source
// after the last one granted. Each output word carries its source index so a
// downstream router can steer replies back.
//
// Ports:
//   clk                 system clock, rising edge
//   resetn              asynchronous active-low reset
//   din0..din3          source data words (DATA_WIDTH)
//   din_valid[3:0]      per-source valid
//   din_ready[3:0]      per-source accept strobe (combinational, one-hot or 0)
//   dout                merged output word (registered)
//   dout_addr[1:0]      source index of dout (registered)
//   dout_valid          output valid (registered)
//   dout_ready          sink accepts dout this cycle
//
// Optional feature (macro SIMPLE_MERGER_STATS_EN):
//   xfer_cnt0..xfer_cnt3  16-bit wrapping counts of words accepted per source
// -----------------------------------------------------------------------------
module simple_merger #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [3:0]            din_valid,
    output logic [3:0]            din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            dout_addr,
    output logic                  dout_valid,
    input  logic                  dout_ready
`ifdef SIMPLE_MERGER_STATS_EN
    ,
    output logic [15:0]           xfer_cnt0,
    output logic [15:0]           xfer_cnt1,
    output logic [15:0]           xfer_cnt2,
    output logic [15:0]           xfer_cnt3
`endif
);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [1:0]            dout_addr_q, dout_addr_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [1:0]            ptr_q, ptr_d;

    logic                  load;
    logic                  found;
    logic                  accept;
    logic [1:0]            grant;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] sel_data;

    // Arbitration and next-state. The register accepts a new word whenever it
    // is empty or being drained this cycle, so drain and refill share an edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        load         = !dout_valid_q || dout_ready;
        grant        = ptr_q;
        found        = 1'b0;
        idx          = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && din_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        accept = load && found;

        // Reset holds the output empty, so load would be 1; gate explicitly so
        // no source sees an accept while resetn is low.
        din_ready = (accept && resetn) ? (4'b0001 << grant) : 4'b0000;

        case (grant)
            2'd0:    sel_data = din0;
            2'd1:    sel_data = din1;
            2'd2:    sel_data = din2;
            default: sel_data = din3;
        endcase

        dout_d       = dout_q;
        dout_addr_d  = dout_addr_q;
        dout_valid_d = dout_valid_q;
        ptr_d        = ptr_q;
        if (load) begin
            if (found) begin
                dout_d       = sel_data;
                dout_addr_d  = grant;
                dout_valid_d = 1'b1;
                ptr_d        = grant + 2'd1;
            end else begin
                // Idle: drop valid, keep the last word and the pointer.
                dout_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q       <= '0;
            dout_addr_q  <= 2'd0;
            dout_valid_q <= 1'b0;
            ptr_q        <= 2'd0;
        end else begin
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            dout_valid_q <= dout_valid_d;
            ptr_q        <= ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_valid = dout_valid_q;

`ifdef SIMPLE_MERGER_STATS_EN
    logic [15:0] xfer_cnt_q [4];
    logic [15:0] xfer_cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xfer_cnt_d[i] = xfer_cnt_q[i];
            if (accept && (grant == 2'(i))) begin
                xfer_cnt_d[i] = xfer_cnt_q[i] + 16'd1;  // wraps 0xFFFF -> 0
            end
        end
    end

    // NOTE: this small array is plain flops, not RAM, so it is safe and required
    // to reset it; a real memory array would be left unreset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) xfer_cnt_q[i] <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) xfer_cnt_q[i] <= xfer_cnt_d[i];
        end
    end

    assign xfer_cnt0 = xfer_cnt_q[0];
    assign xfer_cnt1 = xfer_cnt_q[1];
    assign xfer_cnt2 = xfer_cnt_q[2];
    assign xfer_cnt3 = xfer_cnt_q[3];
`endif

endmodule

// File: tb/tb_simple_merger.sv
// -----------------------------------------------------------------------------
// tb_simple_merger
//
// Directed bench for simple_merger: a table of per-cycle vectors with
// hand-computed expectations, plus hand-written sequences for reset, the
// round-robin rotation, backpressure and the optional statistics counters
// (compiled in with SIMPLE_MERGER_STATS_EN).
// -----------------------------------------------------------------------------
module tb_simple_merger;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] din0, din1, din2, din3;
    logic [3:0]    din_valid;
    logic [3:0]    din_ready;
    logic [DW-1:0] dout;
    logic [1:0]    dout_addr;
    logic          dout_valid;
    logic          dout_ready;
`ifdef SIMPLE_MERGER_STATS_EN
    logic [15:0]   xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    simple_merger #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef SIMPLE_MERGER_STATS_EN
        ,
        .xfer_cnt0  (xfer_cnt0),
        .xfer_cnt1  (xfer_cnt1),
        .xfer_cnt2  (xfer_cnt2),
        .xfer_cnt3  (xfer_cnt3)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle: drive inputs just after an edge, check the combinational
    // din_ready, take the edge, then check the registered outputs.
    task automatic step(input string name, input logic [3:0] dv, input logic dr,
                        input logic [3:0] exp_rdy, input logic [31:0] exp_dout,
                        input logic [1:0] exp_addr, input logic exp_valid);
        din_valid  = dv;
        dout_ready = dr;
        #1;
        check({name, ".din_ready"}, 32'(din_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({name, ".dout"}, dout, exp_dout);
        check({name, ".dout_addr"}, 32'(dout_addr), 32'(exp_addr));
        check({name, ".dout_valid"}, 32'(dout_valid), 32'(exp_valid));
    endtask

    typedef struct {
        string       name;
        logic [3:0]  dv;
        logic        dr;
        logic [3:0]  exp_rdy;
        logic [31:0] exp_dout;
        logic [1:0]  exp_addr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Sequence starts with ptr=3 and dout holding a valid word.
        vecs[0]  = '{"wrap_to_0",    4'b0011, 1'b1, 4'b0001, 32'hA0, 2'd0, 1'b1};
        vecs[1]  = '{"then_1",       4'b0011, 1'b1, 4'b0010, 32'hA1, 2'd1, 1'b1};
        vecs[2]  = '{"idle_drain",   4'b0000, 1'b1, 4'b0000, 32'hA1, 2'd1, 1'b0};
        vecs[3]  = '{"idle_noready", 4'b0000, 1'b0, 4'b0000, 32'hA1, 2'd1, 1'b0};
        vecs[4]  = '{"fill_empty",   4'b1111, 1'b0, 4'b0100, 32'hA2, 2'd2, 1'b1};
        vecs[5]  = '{"stall_a",      4'b1111, 1'b0, 4'b0000, 32'hA2, 2'd2, 1'b1};
        vecs[6]  = '{"stall_b",      4'b1111, 1'b0, 4'b0000, 32'hA2, 2'd2, 1'b1};
        vecs[7]  = '{"resume_3",     4'b1111, 1'b1, 4'b1000, 32'hA3, 2'd3, 1'b1};
        vecs[8]  = '{"wrap_0",       4'b1111, 1'b1, 4'b0001, 32'hA0, 2'd0, 1'b1};
        vecs[9]  = '{"only0_ptr1",   4'b0001, 1'b1, 4'b0001, 32'hA0, 2'd0, 1'b1};
        vecs[10] = '{"only3_ptr1",   4'b1000, 1'b1, 4'b1000, 32'hA3, 2'd3, 1'b1};

        resetn     = 1'b0;
        din0       = 32'hA0;
        din1       = 32'hA1;
        din2       = 32'hBEAD;
        din3       = 32'hA3;
        din_valid  = 4'b0000;
        dout_ready = 1'b0;

        // Reset state, with a request pending to prove din_ready stays low.
        repeat (2) @(posedge clk);
        din_valid = 4'b1111;
        #1;
        check("rst.dout", dout, 32'h0);
        check("rst.dout_addr", 32'(dout_addr), 32'h0);
        check("rst.dout_valid", 32'(dout_valid), 32'h0);
        check("rst.din_ready", 32'(din_ready), 32'h0);
        din_valid = 4'b0000;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single source 2: ptr moves 0 -> 3.
        step("single2", 4'b0100, 1'b1, 4'b0100, 32'hBEAD, 2'd2, 1'b1);
        din2 = 32'hA2;

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].dv, vecs[i].dr, vecs[i].exp_rdy,
                 vecs[i].exp_dout, vecs[i].exp_addr, vecs[i].exp_valid);
        end

        // ptr=0 now; accept source 1 so ptr=2, then reset mid-cycle.
        step("pre_rst", 4'b0010, 1'b1, 4'b0010, 32'hA1, 2'd1, 1'b1);
        din_valid = 4'b1111;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst.dout", dout, 32'h0);
        check("midrst.dout_addr", 32'(dout_addr), 32'h0);
        check("midrst.dout_valid", 32'(dout_valid), 32'h0);
        check("midrst.din_ready", 32'(din_ready), 32'h0);
        din_valid = 4'b0000;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // All four requesting: pointer restarts at 0 after reset.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("rr%0d", i), 4'b1111, 1'b1, 4'b0001 << (i % 4),
                 32'hA0 + 32'(i % 4), 2'(i % 4), 1'b1);
        end

        // Backpressure with dout=A1, then refill on the draining edge.
        step("bp_load", 4'b0010, 1'b1, 4'b0010, 32'hA1, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("bp_hold%0d", i), 4'b1111, 1'b0, 4'b0000, 32'hA1, 2'd1, 1'b1);
        end
        step("bp_release", 4'b1111, 1'b1, 4'b0100, 32'hA2, 2'd2, 1'b1);

`ifdef SIMPLE_MERGER_STATS_EN
        din_valid = 4'b0000;
        resetn    = 1'b0;
        #1;
        check("cnt_rst0", 32'(xfer_cnt0), 32'h0);
        check("cnt_rst2", 32'(xfer_cnt2), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("s1_%0d", i), 4'b0010, 1'b1, 4'b0010, 32'hA1, 2'd1, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            step($sformatf("s3_%0d", i), 4'b1000, 1'b1, 4'b1000, 32'hA3, 2'd3, 1'b1);
        end
        check("cnt0", 32'(xfer_cnt0), 32'd0);
        check("cnt1", 32'(xfer_cnt1), 32'd5);
        check("cnt2", 32'(xfer_cnt2), 32'd0);
        check("cnt3", 32'(xfer_cnt3), 32'd2);

        // Preload counter 0 to 0xFFFF by streaming accepts, then wrap it.
        din_valid = 4'b0000;
        resetn    = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        din_valid  = 4'b0001;
        dout_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("cnt0_full", 32'(xfer_cnt0), 32'h0000FFFF);
        @(posedge clk);
        #1;
        check("cnt0_wrap", 32'(xfer_cnt0), 32'h0);
        check("cnt1_clear", 32'(xfer_cnt1), 32'h0);
        din_valid = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
